// File: rtl/cpu_types_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu_types_pkg
// Brief  : Shared CPU word type, fetch FSM state type and byte-width constant.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

   localparam int WORD_BYTES = 4;

   typedef logic [31:0] word_t;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module : fetch_unit_if
// Brief  : Fetch unit bus: instruction-memory port, IF/ID slot and control.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if #(
   parameter int WORD_W = 32
);
   logic              ihit;
   logic [WORD_W-1:0] imemload;
   logic              stall_in;
   logic              redirect;
   logic [WORD_W-1:0] redirect_pc;
   logic              halt;
   logic              iren;
   logic [WORD_W-1:0] imemaddr;
   logic              instr_valid;
   logic [WORD_W-1:0] instr_out;
   logic [WORD_W-1:0] pc_out;
   logic [WORD_W-1:0] npc_out;

   // slave is the fetch unit's own view; master is the surrounding pipeline/memory
   modport slave (
      input  ihit, imemload, stall_in, redirect, redirect_pc, halt,
      output iren, imemaddr, instr_valid, instr_out, pc_out, npc_out
   );

   modport master (
      output ihit, imemload, stall_in, redirect, redirect_pc, halt,
      input  iren, imemaddr, instr_valid, instr_out, pc_out, npc_out
   );
endinterface

`default_nettype wire

// File: rtl/fetch_pc_gen.sv
//------------------------------------------------------------------------------
// Module : fetch_pc_gen
// Brief  : Program counter register and next-PC select (hold/+4/redirect).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_pc_gen
   import cpu_types_pkg::*;
#(
   parameter int                WORD_W  = 32,
   parameter logic [WORD_W-1:0] PC_INIT = '0
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              hold,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   input  logic              advance,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] pc_plus4
);

   logic [WORD_W-1:0] pc_next;

   assign pc_plus4 = pc + WORD_W'(WORD_BYTES);

   // hold covers both the halting cycle and the HALTED state
   always_comb begin
      pc_next = pc;
      if (hold) begin
         pc_next = pc;
      end else if (redirect) begin
         pc_next = {redirect_pc[WORD_W-1:2], 2'b00};
      end else if (advance) begin
         pc_next = pc_plus4;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pc <= PC_INIT;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module : fetch_unit
// Brief  : Instruction fetch front end with IF/ID output slot, redirect, halt.
//          Optional perf counters enabled by macro FETCH_PERF_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter int                WORD_W  = 32,
   parameter logic [WORD_W-1:0] PC_INIT = '0
) (
   input  logic         CLK,
   input  logic         nRST,
   fetch_unit_if.slave  bus
`ifdef FETCH_PERF_EN
   ,
   output word_t        fetch_count,
   output word_t        imiss_count
`endif
);

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic              halted;
   logic              slot_free;
   logic              fetch_req;
   logic              accept;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] pc_plus4;

   assign halted    = (state == HALTED);
   assign slot_free = !bus.instr_valid || !bus.stall_in;
   assign fetch_req = !halted && slot_free && !bus.redirect && !bus.halt;
   assign accept    = fetch_req && bus.ihit;

   // nRST gating keeps the request low during reset without waiting for an edge
   assign bus.iren     = fetch_req && nRST;
   assign bus.imemaddr = pc;

   fetch_pc_gen #(
      .WORD_W  (WORD_W),
      .PC_INIT (PC_INIT)
   ) u_pc_gen (
      .CLK         (CLK),
      .nRST        (nRST),
      .hold        (halted || bus.halt),
      .redirect    (bus.redirect),
      .redirect_pc (bus.redirect_pc),
      .advance     (accept),
      .pc          (pc),
      .pc_plus4    (pc_plus4)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (bus.halt) state_next = HALTED;
         HALTED:  state_next = HALTED;
         default: state_next = RUN;
      endcase
   end

   // Priority: halt > redirect > fetch accept > consume
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         bus.instr_valid <= 1'b0;
         bus.instr_out   <= '0;
         bus.pc_out      <= '0;
         bus.npc_out     <= '0;
      end else if (!halted) begin
         if (bus.halt || bus.redirect) begin
            bus.instr_valid <= 1'b0;
         end else if (accept) begin
            bus.instr_valid <= 1'b1;
            bus.instr_out   <= bus.imemload;
            bus.pc_out      <= pc;
            bus.npc_out     <= pc_plus4;
         end else if (!bus.stall_in) begin
            bus.instr_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_count <= '0;
         imiss_count <= '0;
      end else if (!halted) begin
         if (accept && (fetch_count != '1)) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (fetch_req && !bus.ihit && (imiss_count != '1)) begin
            imiss_count <= imiss_count + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module : tb_fetch_unit
// Brief  : Self-checking bench for fetch_unit against a transaction-level model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

   localparam logic [31:0] PC_INIT = 32'h0000_0000;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   fetch_unit_if #(.WORD_W(32)) bus();

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] imiss_count;
`endif

   fetch_unit #(
      .WORD_W  (32),
      .PC_INIT (PC_INIT)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
`ifdef FETCH_PERF_EN
      ,
      .fetch_count (fetch_count),
      .imiss_count (imiss_count)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Model state: next fetch address plus the IF/ID slot contents
   logic [31:0] m_pc, m_instr, m_pco, m_npc;
   bit          m_valid, m_halted;
   int          halted_cycles = 0;
   longint      m_fetches, m_misses;

   function automatic void model_reset();
      m_pc = PC_INIT; m_valid = 0; m_halted = 0;
      m_instr = 0; m_pco = 0; m_npc = 0;
      m_fetches = 0; m_misses = 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_req();
      return nRST && !m_halted && (!m_valid || !bus.stall_in) && !bus.redirect && !bus.halt;
   endfunction

   task automatic compare();
      check("iren",        {31'd0, bus.iren},        {31'd0, model_req()});
      check("imemaddr",    bus.imemaddr,             m_pc);
      check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
      check("instr_out",   bus.instr_out,            m_instr);
      check("pc_out",      bus.pc_out,               m_pco);
      check("npc_out",     bus.npc_out,              m_npc);
`ifdef FETCH_PERF_EN
      check("fetch_count", fetch_count, (m_fetches > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_fetches[31:0]);
      check("imiss_count", imiss_count, (m_misses  > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_misses[31:0]);
`endif
   endtask

   // Apply the rules for one clock edge given the inputs currently on the bus
   function automatic void model_step();
      bit req = model_req();
      if (m_halted) return;
      if (req && bus.ihit)  m_fetches++;
      if (req && !bus.ihit) m_misses++;
      if (bus.halt) begin
         m_halted = 1; m_valid = 0;
      end else if (bus.redirect) begin
         m_pc = bus.redirect_pc & 32'hFFFF_FFFC; m_valid = 0;
      end else if (req && bus.ihit) begin
         m_instr = bus.imemload; m_pco = m_pc; m_npc = m_pc + 32'd4;
         m_pc = m_pc + 32'd4; m_valid = 1;
      end else if (!bus.stall_in) begin
         m_valid = 0;
      end
   endfunction

   task automatic drive(input bit ihit, input logic [31:0] load, input bit stall,
                        input bit redir, input logic [31:0] rpc, input bit hlt);
      @(negedge CLK);
      bus.ihit = ihit; bus.imemload = load; bus.stall_in = stall;
      bus.redirect = redir; bus.redirect_pc = rpc; bus.halt = hlt;
      #1;
      compare();
      model_step();
      @(posedge CLK);
      #1;
   endtask

   // Asynchronous reset mid-cycle, released just after a rising edge
   task automatic do_reset();
      @(negedge CLK);
      #2;
      bus.ihit = 0; bus.stall_in = 0; bus.redirect = 0; bus.halt = 0;
      nRST = 0;
      model_reset();
      #1;
      compare();
      check("rst_imemaddr", bus.imemaddr, PC_INIT);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      nRST = 1;
   endtask

   initial begin
      logic [31:0] rpc;
      bus.ihit = 0; bus.imemload = 0; bus.stall_in = 0;
      bus.redirect = 0; bus.redirect_pc = 0; bus.halt = 0;
      model_reset();
      #3;
      compare();
      check("reset_iren",  {31'd0, bus.iren},        32'd0);
      check("reset_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("reset_pcout", bus.pc_out,               32'd0);
      @(posedge CLK); #1; nRST = 1;

      // first fetch
      drive(1, 32'h2001_0005, 0, 0, 0, 0);
      check("f1_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("f1_instr", bus.instr_out, 32'h2001_0005);
      check("f1_pc",    bus.pc_out,    32'h0);
      check("f1_npc",   bus.npc_out,   32'h4);
      check("f1_addr",  bus.imemaddr,  32'h4);
      drive(1, 32'h1111_1111, 0, 0, 0, 0);
      check("f2_pc", bus.pc_out, 32'h4);

      // stall holds slot and pc
      for (int i = 0; i < 2; i++) begin
         drive(1, 32'h2222_2222, 1, 0, 0, 0);
         check("stall_iren",  {31'd0, bus.iren}, 32'd0);
         check("stall_pcout", bus.pc_out,   32'h4);
         check("stall_instr", bus.instr_out, 32'h1111_1111);
         check("stall_addr",  bus.imemaddr,  32'h8);
      end
      drive(1, 32'h3333_3333, 0, 0, 0, 0);
      check("unstall_pc",    bus.pc_out,    32'h8);
      check("unstall_instr", bus.instr_out, 32'h3333_3333);

      // misses
      for (int i = 0; i < 3; i++) begin
         drive(0, 32'hDEAD_BEEF, 0, 0, 0, 0);
         check("miss_iren",  {31'd0, bus.iren},        32'd1);
         check("miss_addr",  bus.imemaddr,             32'hC);
         check("miss_valid", {31'd0, bus.instr_valid}, 32'd0);
      end

      // redirect with simultaneous ihit
      drive(1, 32'h4444_4444, 0, 1, 32'h0000_0043, 0);
      check("redir_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("redir_addr",  bus.imemaddr,  32'h40);
      check("redir_instr", bus.instr_out, 32'h3333_3333);

      // pc wrap
      drive(0, 0, 0, 1, 32'hFFFF_FFFE, 0);
      check("wrap_addr0", bus.imemaddr, 32'hFFFF_FFFC);
      drive(1, 32'h5555_5555, 0, 0, 0, 0);
      check("wrap_pc",   bus.pc_out,   32'hFFFF_FFFC);
      check("wrap_npc",  bus.npc_out,  32'h0);
      check("wrap_addr", bus.imemaddr, 32'h0);
      drive(1, 32'h6666_6666, 0, 0, 0, 0);

      // halt beats redirect, then is terminal
      drive(1, 32'h7777_7777, 0, 1, 32'h100, 1);
      check("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("halt_addr",  bus.imemaddr, 32'h4);
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h8888_8888, 0, i == 1, 32'h200, 0);
         check("halted_iren", {31'd0, bus.iren}, 32'd0);
         check("halted_addr", bus.imemaddr, 32'h4);
      end
      do_reset();
      drive(1, 32'h9999_9999, 0, 0, 0, 0);
      check("post_rst_pc",    bus.pc_out,    PC_INIT);
      check("post_rst_instr", bus.instr_out, 32'h9999_9999);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ((m_halted && halted_cycles > 3) || $urandom_range(0, 399) == 0) begin
            do_reset();
            halted_cycles = 0;
         end
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3,
               $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 99) == 0);
         halted_cycles = m_halted ? halted_cycles + 1 : 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end of the pipelined CPU. It owns the program counter, drives the instruction-memory request, and presents a registered {instruction, PC, NPC} triple to the IF/ID stage through a valid/stall handshake. It also handles branch/jump redirects with a fetch-slot flush, and halts permanently on a halt request.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded at reset (bits [1:0] must be 0).
WORD_W, 32, instruction and address width.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous, active-low reset.
ihit  in  1  instruction memory has returned imemload for imemaddr this cycle.
imemload  in  WORD_W  instruction word from instruction memory.
stall_in  in  1  downstream (IF/ID) cannot accept this cycle.
redirect  in  1  branch/jump taken; flush and refetch from redirect_pc.
redirect_pc  in  WORD_W  redirect target.
halt  in  1  halt instruction retired; stop fetching.
iren  out  1  instruction read enable.
imemaddr  out  WORD_W  instruction fetch address (the current PC).
instr_valid  out  1  output slot holds a valid instruction.
instr_out  out  WORD_W  fetched instruction.
pc_out  out  WORD_W  PC of instr_out.
npc_out  out  WORD_W  pc_out + 4.

Behaviour:
- Reset (async, nRST=0):
  - pc = PC_INIT; state = RUN.
  - instr_valid = 0; instr_out = pc_out = npc_out = 0.
  - iren = 0 while nRST is low.
- States:
  - RUN: normal fetching.
  - HALTED: terminal until reset.
- Output slot: a single register. Its content is consumed on any cycle where instr_valid && !stall_in.
- Combinational signals:
  - slot_free = !instr_valid || !stall_in.
  - imemaddr = pc at all times.
  - iren = (state==RUN) && slot_free && !redirect && !halt.
- Fetch accept: iren && ihit. At the next edge:
  - instr_out <= imemload, pc_out <= pc, npc_out <= pc+4, instr_valid <= 1.
  - pc <= pc+4.
  - Latency is one cycle from ihit to instr_valid.
- Consume without a new fetch: instr_valid && !stall_in && !(iren && ihit) sets instr_valid <= 0 at the next edge. instr_out/pc_out/npc_out hold their old values.
- Stall: instr_valid && stall_in holds all slot registers and pc; iren = 0.
- iren && !ihit: pc and slot unchanged; the request stays asserted.
- Redirect (priority over fetch and consume):
  - pc <= {redirect_pc[WORD_W-1:2], 2'b00}; instr_valid <= 0.
  - Any ihit in the same cycle is discarded.
  - Slot data registers hold.
- Halt (priority over redirect): state <= HALTED, instr_valid <= 0, pc holds. In HALTED, iren = 0 and all inputs except nRST are ignored.
- Arithmetic: pc+4 is modulo 2^WORD_W, so 32'hFFFF_FFFC + 4 = 32'h0.
- Simultaneous stall_in and redirect: redirect wins and the slot is flushed.
- Reset mid-operation: the reset values above apply immediately, regardless of state or outstanding ihit.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds output fetch_count (32), which increments on each fetch accept.
  - Adds output imiss_count (32), which increments on each cycle with iren && !ihit.
  - Both counters reset to 0 on nRST, saturate at 32'hFFFF_FFFF, and freeze in HALTED.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_types_pkg:
  - word_t (logic [31:0]).
  - fetch_state_t enum {RUN, HALTED}.
  - WORD_BYTES = 4.
- Sub-module fetch_pc_gen: the next-PC mux (hold / pc+4 / aligned redirect_pc / halt-hold) and the PC register with PC_INIT.
- fetch_unit instantiates fetch_pc_gen and owns the output slot, the FSM and the optional counters.

Test Plan:
- Reset then ihit=1, stall_in=0, imemload=32'h2001_0005 -> next cycle instr_valid=1, instr_out=32'h2001_0005, pc_out=0, npc_out=4, imemaddr=4.
- Hold ihit=0 for 3 cycles at pc=8 -> iren=1, imemaddr=8 throughout, instr_valid stays 0 once the prior slot is consumed; with FETCH_PERF_EN, imiss_count=3.
- Slot valid (pc_out=4), stall_in=1 for 2 cycles with ihit=1 -> iren=0, slot holds 4, pc holds 8; on release with ihit=1 the slot updates to pc_out=8 in one cycle, with no bubble.
- redirect=1, redirect_pc=32'h0000_0043, ihit=1 at the same time -> ihit data dropped, next cycle instr_valid=0, imemaddr=32'h0000_0040.
- pc=32'hFFFF_FFFC, ihit=1 -> npc_out=32'hFFFF_FFFC+4=0, imemaddr=0.
- halt=1 together with redirect=1 -> HALTED, iren=0, instr_valid=0, imemaddr frozen; nRST pulse -> imemaddr=PC_INIT, fetching resumes.
